// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling, 8N1-style framing.
// Optional even-parity bit between data and stop enabled by `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int WIDTH         = 8,
  parameter int DIVISOR       = 100,
  parameter bit LITTLE_ENDIAN = 1
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_rx,
  output logic [WIDTH-1:0] o_data,
  output logic             o_dv,
  output logic             o_busy,
  output logic             o_frame_err,
  output logic             o_parity_err
);

  localparam int CW = $clog2(DIVISOR);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(DIVISOR - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_next;
  logic             rx_meta, rx_s, rx_d;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_err;
  logic             at_full;

  assign at_full = (cnt == FULL_M1);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (rx_d && !rx_s) state_next = START;
      START: if (cnt == HALF_M1) state_next = rx_s ? IDLE : DATA;
      DATA:
        if (at_full && bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      PARITY: if (at_full) state_next = STOP;
`endif
      STOP:    if (at_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != IDLE);
  end

  // The sub-bit counter restarts on every state change and wraps each data bit.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_dv        <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_dv        <= 1'b0;
      o_frame_err <= 1'b0;

      if (state == IDLE || state_next != state || (state == DATA && at_full))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      if (state != DATA)
        bit_cnt <= '0;
      else if (at_full) begin
        bit_cnt <= bit_cnt + BW'(1);
        if (LITTLE_ENDIAN) shreg <= {rx_s, shreg[WIDTH-1:1]};
        else               shreg <= {shreg[WIDTH-2:0], rx_s};
      end

      if (state == STOP && at_full) begin
        if (rx_s && !par_err) begin
          o_data <= shreg;
          o_dv   <= 1'b1;
        end
        if (!rx_s) o_frame_err <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Mismatch is remembered until the stop sample so both errors can be reported together.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      par_err      <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      o_parity_err <= 1'b0;
      if (state == START)
        par_err <= 1'b0;
      else if (state == PARITY && at_full)
        par_err <= (rx_s != ^shreg);
      if (state == STOP && at_full && par_err)
        o_parity_err <= 1'b1;
    end
  end
`else
  assign par_err      = 1'b0;
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: drives serial frames and compares
// received words, error pulses and latency against a frame-level reference model.
module tb_uart_rx;

  localparam int D = 16;
  localparam int W = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LAT = 3 + D / 2 + (W + 1 + PAR) * D;

  logic         clk;
  logic         i_reset;
  logic         i_rx;
  logic [W-1:0] o_data, be_data;
  logic         o_dv, o_busy, o_frame_err, o_parity_err;
  logic         be_dv, be_busy, be_frame_err, be_parity_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int fe_count = 0;
  int pe_count = 0;
  logic [W-1:0] dv_q[$];
  int           dv_cyc_q[$];
  logic [W-1:0] be_q[$];
  logic [W-1:0] exp_last = '0;

  uart_rx #(.WIDTH(W), .DIVISOR(D), .LITTLE_ENDIAN(1)) dut (
    .clk(clk), .i_reset(i_reset), .i_rx(i_rx),
    .o_data(o_data), .o_dv(o_dv), .o_busy(o_busy),
    .o_frame_err(o_frame_err), .o_parity_err(o_parity_err)
  );

  uart_rx #(.WIDTH(W), .DIVISOR(D), .LITTLE_ENDIAN(0)) dut_be (
    .clk(clk), .i_reset(i_reset), .i_rx(i_rx),
    .o_data(be_data), .o_dv(be_dv), .o_busy(be_busy),
    .o_frame_err(be_frame_err), .o_parity_err(be_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (o_dv) begin
      dv_q.push_back(o_data);
      dv_cyc_q.push_back(cyc);
    end
    if (be_dv) be_q.push_back(be_data);
    if (o_frame_err) fe_count++;
    if (o_parity_err) pe_count++;
    if (o_dv && (o_frame_err || o_parity_err)) checkOutput("dv_err_overlap", 1, 0);
  end

  // The first wire bit lands in the MSB when the receiver is big-endian.
  function automatic logic [W-1:0] firstBitMsb(input logic [W-1:0] d);
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++) r[W-1-i] = d[i];
    return r;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] data, input logic stop_bit, input logic par_bit);
    i_rx = 1'b0;
    fall_cyc = cyc;
    repeat (D) @(negedge clk);
    for (int i = 0; i < W; i++) begin
      i_rx = data[i];
      repeat (D) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = par_bit;
    repeat (D) @(negedge clk);
`else
    if (par_bit === 1'bz) i_rx = 1'b1;
`endif
    i_rx = stop_bit;
    repeat (D) @(negedge clk);
    i_rx = 1'b1;
    if (!stop_bit) repeat (D) @(negedge clk);
  endtask

  task automatic runFrame(input logic [W-1:0] data, input logic stop_ok, input logic par_ok, input int gap);
    int  n0, nb0, fe0, pe0, lat;
    logic good;
    n0  = dv_q.size();
    nb0 = be_q.size();
    fe0 = fe_count;
    pe0 = pe_count;
    applyStimulus(data, stop_ok, (^data) ^ !par_ok);
    repeat (gap) @(negedge clk);
    #1;
    good = stop_ok && (PAR == 0 || par_ok);
    if (good) begin
      exp_last = data;
      checkOutput("dv_count", dv_q.size() - n0, 1);
      if (dv_q.size() > n0) begin
        checkOutput("data", dv_q[n0], data);
        lat = dv_cyc_q[n0] - fall_cyc;
        checkOutput("latency", (lat >= LAT - 2 && lat <= LAT + 2) ? LAT : lat, LAT);
      end
      checkOutput("be_data", (be_q.size() > nb0) ? be_q[nb0] : 'x, firstBitMsb(data));
    end else begin
      checkOutput("dv_count", dv_q.size() - n0, 0);
    end
    checkOutput("held_data", o_data, exp_last);
    checkOutput("fe_count", fe_count - fe0, stop_ok ? 0 : 1);
    checkOutput("pe_count", pe_count - pe0, (PAR != 0 && !par_ok) ? 1 : 0);
  endtask

  initial begin
    int   n0, fe0;
    logic busy_seen;
    i_reset = 1'b1;
    i_rx    = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_data", o_data, 0);
    checkOutput("rst_dv", o_dv, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_ferr", o_frame_err, 0);
    checkOutput("rst_perr", o_parity_err, 0);
    i_reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("idle_quiet", {o_dv, o_busy, o_frame_err, o_parity_err, o_data}, 0);
    end

    runFrame(8'hA5, 1'b1, 1'b1, 4);
    runFrame(8'h01, 1'b1, 1'b1, 4);
    runFrame(8'h00, 1'b1, 1'b1, 0);
    runFrame(8'hFF, 1'b1, 1'b1, 0);
    runFrame(8'h3C, 1'b1, 1'b1, 8);

    // Short low glitch must be rejected at the start-bit midpoint.
    n0 = dv_q.size();
    fe0 = fe_count;
    busy_seen = 1'b0;
    i_rx = 1'b0;
    repeat (5) @(negedge clk);
    i_rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      busy_seen |= o_busy;
    end
    #1;
    checkOutput("glitch_busy", busy_seen, 1);
    checkOutput("glitch_dv", dv_q.size() - n0, 0);
    checkOutput("glitch_fe", fe_count - fe0, 0);
    checkOutput("glitch_idle", o_busy, 0);

    runFrame(8'h55, 1'b0, 1'b1, 4);

    // Break: one framing error, then silence while the line stays low.
    n0 = dv_q.size();
    fe0 = fe_count;
    i_rx = 1'b0;
    repeat (3 * (W + 2 + PAR) * D) @(negedge clk);
    #1;
    checkOutput("break_fe", fe_count - fe0, 1);
    checkOutput("break_dv", dv_q.size() - n0, 0);
    checkOutput("break_data", o_data, exp_last);
    i_rx = 1'b1;
    repeat (D) @(negedge clk);
    runFrame(8'hC3, 1'b1, 1'b1, 2);

    // Reset in the middle of the data bits.
    n0 = dv_q.size();
    i_rx = 1'b0;
    repeat (D) @(negedge clk);
    i_rx = 1'b1;
    repeat (3 * D) @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_data", o_data, 0);
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_dv", dv_q.size() - n0, 0);
    checkOutput("midrst_fe", o_frame_err, 0);
    exp_last = '0;
    i_reset = 1'b0;
    repeat ((W + 3) * D) @(negedge clk);
    checkOutput("midrst_quiet", dv_q.size() - n0, 0);
    runFrame(8'h5A, 1'b1, 1'b1, 2);

`ifdef UART_RX_PARITY_EN
    runFrame(8'h07, 1'b1, 1'b1, 2);
    runFrame(8'h07, 1'b1, 1'b0, 2);
`endif

    for (int i = 0; i < 24; i++) begin
      runFrame(W'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
               $urandom_range(0, 3));
    end

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
